lcd_display_ctrl: RTL



---
 rtl/lcd_display_ctrl_pkg.sv | 75 +++++++
 rtl/lcd_display_ctrl_if.sv | 24 ++
 rtl/lcd_display_ctrl_bin_to_bcd_seq.sv | 51 +++++
 rtl/lcd_display_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_display_ctrl_pkg.sv
// Shared definitions for the LCD display controller: opcodes, HD44780 command bytes,
// the mnemonic character table and FSM state types.
package lcd_display_ctrl_pkg;

  // CPU opcodes
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DISP = 3'b111;

  // LCD command bytes
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  // Index of the final byte in the init and update sequences
  localparam logic [4:0] LAST_INIT = 5'd3;
  localparam logic [4:0] LAST_XFER = 5'd17;

  typedef enum logic [2:0] {
    StPwrWait,
    StInit,
    StIdle,
    StConvert,
    StXfer
  } state_e;

  // Phases of a single byte transfer (also reused to sequence CONVERT)
  typedef enum logic [1:0] {
    PhLaunch,
    PhStrobe,
    PhWait
  } phase_e;

  // Five-character mnemonic, leftmost character in the top byte
  function automatic logic [39:0] mnem_str(input logic [2:0] op);
    logic [39:0] s;
    unique case (op)
      OP_LOAD: s = "LOAD ";
      OP_ADD:  s = "ADD  ";
      OP_ADDI: s = "ADDI ";
      OP_SUB:  s = "SUB  ";
      OP_SUBI: s = "SUBI ";
      OP_MUL:  s = "MUL  ";
      OP_CLR:  s = "CLR  ";
      default: s = "DISP ";
    endcase
    return s;
  endfunction

  // Power-on initialisation command sequence
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = FUNC_SET;
      2'd1:    c = DISP_ON;
      2'd2:    c = ENTRY;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

  // Upper-case ASCII hex digit
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_display_ctrl_if.sv
// CPU-side handshake plus LCD pin bundle for lcd_display_ctrl.
interface lcd_display_ctrl_if;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_data;

  // Requester side (CPU / testbench)
  modport master (
    output start, opcode, result,
    input  busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  // Controller side
  modport slave (
    input  start, opcode, result,
    output busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
endinterface

// File: rtl/lcd_display_ctrl_bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble converter, 16-bit binary to 5 BCD digits.
// One shift per cycle; done pulses 17 cycles after start.
module lcd_display_ctrl_bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [35:0] sr_q, sr_adj;
  logic [4:0]  cnt_q;
  logic        run_q, done_q;

  // Add-3 correction on every BCD digit that is 5 or more before the next shift
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (sr_q[16 + 4 * i +: 4] >= 4'd5) begin
        sr_adj[16 + 4 * i +: 4] = sr_q[16 + 4 * i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then 16 correct-and-shift steps
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      sr_q   <= {20'h0, bin};
      cnt_q  <= 5'd16;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      sr_q   <= {sr_adj[34:0], 1'b0};
      cnt_q  <= cnt_q - 5'd1;
      run_q  <= (cnt_q != 5'd1);
      done_q <= (cnt_q == 5'd1);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign bcd  = sr_q[35:16];

endmodule

// File: rtl/lcd_display_ctrl.sv
// HD44780 16x2 LCD controller (8-bit mode) for the mini-CPU result path.
// Line 1: "OP:" + mnemonic; line 2: "=" + signed 5-digit decimal.
// Optional build macro LCD_HEX_EN: line 2 becomes "=0x" + 4 hex digits, no BCD converter.
module lcd_display_ctrl
  import lcd_display_ctrl_pkg::*;
#(
  parameter int unsigned POWERON_WAIT_CYC = 750000,
  parameter int unsigned E_PULSE_CYC      = 12,
  parameter int unsigned CMD_WAIT_CYC     = 2500,
  parameter int unsigned CLEAR_WAIT_CYC   = 80000
) (
  input logic                clk,
  input logic                rst,
  lcd_display_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  phase_e      ph_q, ph_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] res_q, res_d;

  logic        cur_rs;
  logic [7:0]  cur_byte;
  logic [39:0] mn;

`ifndef LCD_HEX_EN
  logic [19:0] digits_q, digits_d;
  logic        neg;
  logic [15:0] mag;
  logic        bcd_start, bcd_done;
  logic [19:0] bcd;

  // Magnitude of the latched result; 0x8000 maps to 32768
  assign neg = res_q[15];
  assign mag = neg ? (~res_q + 16'd1) : res_q;

  lcd_display_ctrl_bin_to_bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (mag),
    .done  (bcd_done),
    .bcd   (bcd)
  );
`endif

  // Byte to launch for the current sequence position
  always_comb begin
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    mn       = mnem_str(op_q);
    if (state_q == StInit) begin
      cur_byte = init_cmd(idx_q[1:0]);
    end else begin
      unique case (idx_q)
        5'd0:  cur_byte = CLEAR;
        5'd1:  cur_byte = LINE1;
        5'd2:  begin cur_rs = 1'b1; cur_byte = "O"; end
        5'd3:  begin cur_rs = 1'b1; cur_byte = "P"; end
        5'd4:  begin cur_rs = 1'b1; cur_byte = ":"; end
        5'd5:  begin cur_rs = 1'b1; cur_byte = mn[39:32]; end
        5'd6:  begin cur_rs = 1'b1; cur_byte = mn[31:24]; end
        5'd7:  begin cur_rs = 1'b1; cur_byte = mn[23:16]; end
        5'd8:  begin cur_rs = 1'b1; cur_byte = mn[15:8]; end
        5'd9:  begin cur_rs = 1'b1; cur_byte = mn[7:0]; end
        5'd10: cur_byte = LINE2;
        5'd11: begin cur_rs = 1'b1; cur_byte = "="; end
`ifdef LCD_HEX_EN
        5'd12: begin cur_rs = 1'b1; cur_byte = "0"; end
        5'd13: begin cur_rs = 1'b1; cur_byte = "x"; end
        5'd14: begin cur_rs = 1'b1; cur_byte = hex_char(res_q[15:12]); end
        5'd15: begin cur_rs = 1'b1; cur_byte = hex_char(res_q[11:8]); end
        5'd16: begin cur_rs = 1'b1; cur_byte = hex_char(res_q[7:4]); end
        5'd17: begin cur_rs = 1'b1; cur_byte = hex_char(res_q[3:0]); end
`else
        5'd12: begin cur_rs = 1'b1; cur_byte = neg ? "-" : "+"; end
        5'd13: begin cur_rs = 1'b1; cur_byte = {4'h3, digits_q[19:16]}; end
        5'd14: begin cur_rs = 1'b1; cur_byte = {4'h3, digits_q[15:12]}; end
        5'd15: begin cur_rs = 1'b1; cur_byte = {4'h3, digits_q[11:8]}; end
        5'd16: begin cur_rs = 1'b1; cur_byte = {4'h3, digits_q[7:4]}; end
        5'd17: begin cur_rs = 1'b1; cur_byte = {4'h3, digits_q[3:0]}; end
`endif
        default: ;
      endcase
    end
  end

  // Next-state: power-on wait, byte-transfer engine, handshake and conversion
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    op_d    = op_q;
    res_d   = res_q;
`ifndef LCD_HEX_EN
    digits_d  = digits_q;
    bcd_start = 1'b0;
`endif
    unique case (state_q)
      StPwrWait: begin
        if (cnt_q == POWERON_WAIT_CYC - 1) begin
          state_d = StInit;
          ph_d    = PhLaunch;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StInit, StXfer: begin
        unique case (ph_q)
          PhLaunch: begin
            e_d    = 1'b1;
            rs_d   = cur_rs;
            data_d = cur_byte;
            cnt_d  = E_PULSE_CYC - 1;
            ph_d   = PhStrobe;
          end
          PhStrobe: begin
            if (cnt_q == '0) begin
              // rs/data stay put through the wait, covering the post-fall hold
              e_d   = 1'b0;
              cnt_d = (!rs_q && data_q == CLEAR) ? CLEAR_WAIT_CYC - 1 : CMD_WAIT_CYC - 1;
              ph_d  = PhWait;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
          default: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 32'd1;
            end else if (idx_q == ((state_q == StInit) ? LAST_INIT : LAST_XFER)) begin
              done_d  = (state_q == StXfer);
              busy_d  = 1'b0;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 5'd1;
              ph_d  = PhLaunch;
            end
          end
        endcase
      end
      StIdle: begin
        if (bus.start) begin
          op_d   = bus.opcode;
          res_d  = bus.result;
          busy_d = 1'b1;
          ph_d   = PhLaunch;
          idx_d  = '0;
`ifdef LCD_HEX_EN
          state_d = StXfer;
`else
          state_d = StConvert;
`endif
        end
      end
      StConvert: begin
`ifdef LCD_HEX_EN
        state_d = StXfer;
`else
        if (ph_q == PhLaunch) begin
          bcd_start = 1'b1;
          ph_d      = PhWait;
        end else if (bcd_done) begin
          digits_d = bcd;
          state_d  = StXfer;
          ph_d     = PhLaunch;
          idx_d    = '0;
        end
`endif
      end
      default: state_d = StPwrWait;
    endcase
  end

  // State and output registers; reset restarts the power-on sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPwrWait;
      ph_q    <= PhLaunch;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      op_q    <= '0;
      res_q   <= '0;
`ifndef LCD_HEX_EN
      digits_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifndef LCD_HEX_EN
      digits_q <= digits_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_data = data_q;

endmodule
